// File: rtl/wave_gen_driver_pkg.sv
// Shared types and constants for the wave generator host driver.
// State encoding, waveform select type and peak-detect seeds.
package wave_gen_driver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_AMP,
    SET_PHASE,
    RUN,
    DONE
  } state_t;

  typedef logic [1:0] waveform_t;

  localparam logic [7:0] PEAK_INIT_MAX = 8'h80;
  localparam logic [7:0] PEAK_INIT_MIN = 8'h7F;

  // Signed greater-than on raw sample bytes.
  function automatic logic s_gt(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/wave_sample_fifo.sv
// Synchronous show-ahead sample FIFO, count-based full/empty.
// Ports: clk/rst_n, wr_en/wr_data, rd_en/rd_data, valid, full.
module wave_sample_fifo
  import wave_gen_driver_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         valid,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign valid   = !empty;
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot, so a full FIFO may accept a push
  // in the same cycle.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wave_gen_driver.sv
// Host driver for the wave generator: programs amp/phase,
// runs N-sample bursts, buffers samples in a FIFO.
// Ports: cmd_* burst command (valid/ready), abort_i,
// gen_* generator pins, smp_* FIFO read port (valid/ready),
// busy_o/overflow_o/done_strobe_o status, peak_max_o/min_o.
// Optional: WAVE_GEN_DRIVER_PEAK_DETECT_EN enables peak tracking.
module wave_gen_driver
  import wave_gen_driver_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_amplitude_i,
  input  logic [7:0]       cmd_phase_i,
  input  logic [1:0]       cmd_waveform_i,
  input  logic [CNT_W-1:0] cmd_num_samples_i,
  input  logic             abort_i,
  output logic             gen_enable_o,
  output logic [1:0]       gen_waveform_o,
  output logic             gen_set_amplitude_strobe_o,
  output logic             gen_set_phase_strobe_o,
  output logic [7:0]       gen_data_o,
  input  logic [7:0]       gen_data_i,
  input  logic             gen_data_valid_strobe_i,
  output logic             smp_valid_o,
  output logic [7:0]       smp_data_o,
  input  logic             smp_ready_i,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             done_strobe_o,
  output logic [7:0]       peak_max_o,
  output logic [7:0]       peak_min_o
);

  state_t           state_q;
  state_t           state_d;
  logic             live_q;
  logic [7:0]       amp_q;
  logic [7:0]       phase_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  waveform_t        wf_q;
  logic             amp_stb_q;
  logic             phase_stb_q;
  logic [7:0]       data_q;
  logic             ovf_q;
  logic             accept;
  logic             smp_run;
  logic             hit;
  logic             fifo_full;
  logic             drop;

  // live_q keeps cmd_ready_o low while reset is asserted.
  assign accept  = (state_q == IDLE) && live_q && cmd_valid_i;
  assign smp_run = (state_q == RUN) && gen_data_valid_strobe_i;
  assign cnt_inc = cnt_q + 1'b1;
  assign hit     = smp_run && (num_q != '0)
                   && (cnt_inc == num_q);
  assign drop    = smp_run && fifo_full && !smp_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept) state_d = SET_AMP;
      SET_AMP:   state_d = abort_i ? DONE : SET_PHASE;
      SET_PHASE: state_d = abort_i ? DONE : RUN;
      RUN:       if (abort_i || hit) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o   = (state_q == IDLE) && live_q;
    busy_o        = (state_q != IDLE);
    gen_enable_o  = (state_q == RUN);
    done_strobe_o = (state_q == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      amp_q   <= '0;
      phase_q <= '0;
      num_q   <= '0;
      wf_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        amp_q   <= cmd_amplitude_i;
        phase_q <= cmd_phase_i;
        num_q   <= cmd_num_samples_i;
        wf_q    <= cmd_waveform_i;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (smp_run) cnt_q <= cnt_inc;
        if (drop)    ovf_q <= 1'b1;
      end
    end
  end

  // Strobes lag the set state by one cycle; abort in the set
  // state suppresses the pending pulse and the bus update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      amp_stb_q   <= 1'b0;
      phase_stb_q <= 1'b0;
      data_q      <= '0;
    end else begin
      amp_stb_q   <= (state_q == SET_AMP) && !abort_i;
      phase_stb_q <= (state_q == SET_PHASE) && !abort_i;
      unique case (1'b1)
        (state_q == SET_AMP) && !abort_i:
          data_q <= amp_q;
        (state_q == SET_PHASE) && !abort_i:
          data_q <= phase_q;
        default:
          data_q <= data_q;
      endcase
    end
  end

  assign gen_waveform_o             = wf_q;
  assign gen_set_amplitude_strobe_o = amp_stb_q;
  assign gen_set_phase_strobe_o     = phase_stb_q;
  assign gen_data_o                 = data_q;
  assign overflow_o                 = ovf_q;

  wave_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .wr_en   (smp_run),
    .wr_data (gen_data_i),
    .rd_en   (smp_ready_i),
    .rd_data (smp_data_o),
    .valid   (smp_valid_o),
    .full    (fifo_full)
  );

`ifdef WAVE_GEN_DRIVER_PEAK_DETECT_EN
  logic [7:0] pmax_q;
  logic [7:0] pmin_q;

  // Dropped samples still count toward the peaks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pmax_q <= '0;
      pmin_q <= '0;
    end else if (accept) begin
      pmax_q <= PEAK_INIT_MAX;
      pmin_q <= PEAK_INIT_MIN;
    end else if (smp_run) begin
      if (s_gt(gen_data_i, pmax_q)) pmax_q <= gen_data_i;
      if (s_gt(pmin_q, gen_data_i)) pmin_q <= gen_data_i;
    end
  end

  assign peak_max_o = pmax_q;
  assign peak_min_o = pmin_q;
`else
  assign peak_max_o = '0;
  assign peak_min_o = '0;
`endif

endmodule

// File: tb/tb_wave_gen_driver.sv
// Directed testbench for wave_gen_driver.
// Burst, overflow, full push/pop, abort, reset, peaks.
module tb_wave_gen_driver;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  cmd_amplitude_i = '0;
  logic [7:0]  cmd_phase_i = '0;
  logic [1:0]  cmd_waveform_i = '0;
  logic [15:0] cmd_num_samples_i = '0;
  logic        abort_i = 1'b0;
  logic        gen_enable_o;
  logic [1:0]  gen_waveform_o;
  logic        gen_set_amplitude_strobe_o;
  logic        gen_set_phase_strobe_o;
  logic [7:0]  gen_data_o;
  logic [7:0]  gen_data_i = '0;
  logic        gen_data_valid_strobe_i = 1'b0;
  logic        smp_valid_o;
  logic [7:0]  smp_data_o;
  logic        smp_ready_i = 1'b0;
  logic        busy_o;
  logic        overflow_o;
  logic        done_strobe_o;
  logic [7:0]  peak_max_o;
  logic [7:0]  peak_min_o;

  int checks = 0;
  int failures = 0;

  wave_gen_driver #(
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .cmd_valid_i                (cmd_valid_i),
    .cmd_ready_o                (cmd_ready_o),
    .cmd_amplitude_i            (cmd_amplitude_i),
    .cmd_phase_i                (cmd_phase_i),
    .cmd_waveform_i             (cmd_waveform_i),
    .cmd_num_samples_i          (cmd_num_samples_i),
    .abort_i                    (abort_i),
    .gen_enable_o               (gen_enable_o),
    .gen_waveform_o             (gen_waveform_o),
    .gen_set_amplitude_strobe_o (gen_set_amplitude_strobe_o),
    .gen_set_phase_strobe_o     (gen_set_phase_strobe_o),
    .gen_data_o                 (gen_data_o),
    .gen_data_i                 (gen_data_i),
    .gen_data_valid_strobe_i    (gen_data_valid_strobe_i),
    .smp_valid_o                (smp_valid_o),
    .smp_data_o                 (smp_data_o),
    .smp_ready_i                (smp_ready_i),
    .busy_o                     (busy_o),
    .overflow_o                 (overflow_o),
    .done_strobe_o              (done_strobe_o),
    .peak_max_o                 (peak_max_o),
    .peak_min_o                 (peak_min_o)
  );

  always #5 clk_i = ~clk_i;

  // Drives a command and returns at the first negedge in RUN.
  task automatic send_cmd(
    input logic [7:0]  amp,
    input logic [7:0]  ph,
    input logic [1:0]  wf,
    input logic [15:0] n
  );
    cmd_amplitude_i   = amp;
    cmd_phase_i       = ph;
    cmd_waveform_i    = wf;
    cmd_num_samples_i = n;
    cmd_valid_i       = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cmd_ready_o, busy_o, gen_enable_o,
         gen_set_amplitude_strobe_o,
         gen_set_phase_strobe_o, smp_valid_o,
         overflow_o, done_strobe_o} !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0",
        {cmd_ready_o, busy_o, gen_enable_o,
         gen_set_amplitude_strobe_o,
         gen_set_phase_strobe_o, smp_valid_o,
         overflow_o, done_strobe_o});
    end
    checks++;
    if ({gen_data_o, gen_waveform_o, peak_max_o,
         peak_min_o} !== 26'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0",
        {gen_data_o, gen_waveform_o, peak_max_o,
         peak_min_o});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1",
        cmd_ready_o);
    end
  endtask

  task automatic test_burst();
    logic [7:0] s;
    cmd_amplitude_i   = 8'h40;
    cmd_phase_i       = 8'h10;
    cmd_waveform_i    = 2'b01;
    cmd_num_samples_i = 16'd4;
    cmd_valid_i       = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    checks++;
    if ({cmd_ready_o, busy_o, gen_waveform_o}
        !== 4'b0101) begin
      failures++;
      $display("FAIL burst_accept got=%b exp=0101",
        {cmd_ready_o, busy_o, gen_waveform_o});
    end
    @(negedge clk_i);
    checks++;
    if ({gen_set_amplitude_strobe_o,
         gen_set_phase_strobe_o, gen_data_o}
        !== {2'b10, 8'h40}) begin
      failures++;
      $display("FAIL burst_amp got=%h exp=240",
        {gen_set_amplitude_strobe_o,
         gen_set_phase_strobe_o, gen_data_o});
    end
    @(negedge clk_i);
    checks++;
    if ({gen_set_amplitude_strobe_o,
         gen_set_phase_strobe_o, gen_enable_o,
         gen_data_o} !== {3'b011, 8'h10}) begin
      failures++;
      $display("FAIL burst_phase got=%h exp=310",
        {gen_set_amplitude_strobe_o,
         gen_set_phase_strobe_o, gen_enable_o,
         gen_data_o});
    end
    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk_i);
      checks++;
      if (gen_enable_o !== 1'b1) begin
        failures++;
        $display("FAIL burst_en%0d got=%b exp=1",
          i, gen_enable_o);
      end
      gen_data_valid_strobe_i = 1'b1;
      gen_data_i = 8'hA0 + 8'(i);
      @(negedge clk_i);
      gen_data_valid_strobe_i = 1'b0;
    end
    checks++;
    if ({gen_enable_o, done_strobe_o} !== 2'b01) begin
      failures++;
      $display("FAIL burst_done got=%b exp=01",
        {gen_enable_o, done_strobe_o});
    end
    @(negedge clk_i);
    checks++;
    if ({done_strobe_o, cmd_ready_o, busy_o}
        !== 3'b010) begin
      failures++;
      $display("FAIL burst_idle got=%b exp=010",
        {done_strobe_o, cmd_ready_o, busy_o});
    end
    for (int i = 0; i < 4; i++) begin
      s = 8'hA0 + 8'(i);
      checks++;
      if ({smp_valid_o, smp_data_o} !== {1'b1, s}) begin
        failures++;
        $display("FAIL burst_pop%0d got=%h exp=%h",
          i, {smp_valid_o, smp_data_o}, {1'b1, s});
      end
      smp_ready_i = 1'b1;
      @(negedge clk_i);
      smp_ready_i = 1'b0;
    end
    checks++;
    if (smp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL burst_empty got=%b exp=0",
        smp_valid_o);
    end
  endtask

  task automatic test_overflow();
    send_cmd(8'h11, 8'h22, 2'b10, 16'd12);
    for (int i = 0; i < 12; i++) begin
      gen_data_valid_strobe_i = 1'b1;
      gen_data_i = 8'h20 + 8'(i);
      @(negedge clk_i);
      if (i == 7) begin
        checks++;
        if (overflow_o !== 1'b0) begin
          failures++;
          $display("FAIL ovf_early got=%b exp=0",
            overflow_o);
        end
      end
      if (i == 8) begin
        checks++;
        if (overflow_o !== 1'b1) begin
          failures++;
          $display("FAIL ovf_set got=%b exp=1",
            overflow_o);
        end
      end
      if (i == 10) begin
        checks++;
        if (done_strobe_o !== 1'b0) begin
          failures++;
          $display("FAIL ovf_early_done got=%b exp=0",
            done_strobe_o);
        end
      end
    end
    gen_data_valid_strobe_i = 1'b0;
    checks++;
    if ({done_strobe_o, smp_valid_o, smp_data_o}
        !== {2'b11, 8'h20}) begin
      failures++;
      $display("FAIL ovf_done got=%h exp=320",
        {done_strobe_o, smp_valid_o, smp_data_o});
    end
    @(negedge clk_i);
  endtask

  task automatic test_full_push_pop();
    logic [7:0] e;
    send_cmd(8'h01, 8'h02, 2'b11, 16'd1);
    checks++;
    if (overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL fpp_clear got=%b exp=0",
        overflow_o);
    end
    gen_data_valid_strobe_i = 1'b1;
    gen_data_i  = 8'h99;
    smp_ready_i = 1'b1;
    @(negedge clk_i);
    gen_data_valid_strobe_i = 1'b0;
    smp_ready_i = 1'b0;
    checks++;
    if ({overflow_o, done_strobe_o, smp_data_o}
        !== {2'b01, 8'h21}) begin
      failures++;
      $display("FAIL fpp_head got=%h exp=121",
        {overflow_o, done_strobe_o, smp_data_o});
    end
    @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      e = (i < 7) ? 8'h21 + 8'(i) : 8'h99;
      checks++;
      if ({smp_valid_o, smp_data_o} !== {1'b1, e}) begin
        failures++;
        $display("FAIL fpp_pop%0d got=%h exp=%h",
          i, {smp_valid_o, smp_data_o}, {1'b1, e});
      end
      smp_ready_i = 1'b1;
      @(negedge clk_i);
      smp_ready_i = 1'b0;
    end
    checks++;
    if (smp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL fpp_empty got=%b exp=0",
        smp_valid_o);
    end
  endtask

  task automatic test_abort();
    send_cmd(8'h33, 8'h44, 2'b00, 16'd0);
    smp_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      gen_data_valid_strobe_i = 1'b1;
      gen_data_i = 8'h50 + 8'(i);
      abort_i = (i == 19);
      @(negedge clk_i);
      if (i == 18) begin
        checks++;
        if (gen_enable_o !== 1'b1) begin
          failures++;
          $display("FAIL abort_run got=%b exp=1",
            gen_enable_o);
        end
      end
    end
    smp_ready_i = 1'b0;
    gen_data_valid_strobe_i = 1'b0;
    abort_i = 1'b0;
    checks++;
    if ({gen_enable_o, done_strobe_o, overflow_o,
         smp_valid_o, smp_data_o}
        !== {4'b0101, 8'h63}) begin
      failures++;
      $display("FAIL abort_done got=%h exp=563",
        {gen_enable_o, done_strobe_o, overflow_o,
         smp_valid_o, smp_data_o});
    end
    @(negedge clk_i);
    checks++;
    if ({cmd_ready_o, smp_valid_o, smp_data_o}
        !== {2'b11, 8'h63}) begin
      failures++;
      $display("FAIL abort_keep got=%h exp=363",
        {cmd_ready_o, smp_valid_o, smp_data_o});
    end
  endtask

  task automatic test_reset_mid_burst();
    cmd_amplitude_i   = 8'h77;
    cmd_phase_i       = 8'h88;
    cmd_num_samples_i = 16'd5;
    cmd_valid_i       = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (gen_set_amplitude_strobe_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got=%b exp=1",
        gen_set_amplitude_strobe_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({gen_set_amplitude_strobe_o, smp_valid_o,
         busy_o, cmd_ready_o} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_set_state got=%b exp=0000",
        {gen_set_amplitude_strobe_o, smp_valid_o,
         busy_o, cmd_ready_o});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=1",
        cmd_ready_o);
    end
    send_cmd(8'h12, 8'h34, 2'b01, 16'd0);
    gen_data_valid_strobe_i = 1'b1;
    gen_data_i = 8'h5A;
    @(negedge clk_i);
    gen_data_valid_strobe_i = 1'b0;
    checks++;
    if ({gen_enable_o, smp_valid_o} !== 2'b11) begin
      failures++;
      $display("FAIL rst_run_pre got=%b exp=11",
        {gen_enable_o, smp_valid_o});
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if ({gen_enable_o, gen_set_phase_strobe_o,
         smp_valid_o, busy_o} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_run got=%b exp=0000",
        {gen_enable_o, gen_set_phase_strobe_o,
         smp_valid_o, busy_o});
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_run_ready got=%b exp=1",
        cmd_ready_o);
    end
  endtask

  task automatic test_peak();
    logic [7:0] smp [3];
    logic [15:0] exp_pk;
    smp[0] = 8'h05;
    smp[1] = 8'hF0;
    smp[2] = 8'h7F;
`ifdef WAVE_GEN_DRIVER_PEAK_DETECT_EN
    exp_pk = 16'h7FF0;
`else
    exp_pk = 16'h0000;
`endif
    send_cmd(8'h01, 8'h01, 2'b00, 16'd3);
    for (int i = 0; i < 3; i++) begin
      gen_data_valid_strobe_i = 1'b1;
      gen_data_i = smp[i];
      @(negedge clk_i);
    end
    gen_data_valid_strobe_i = 1'b0;
    checks++;
    if ({peak_max_o, peak_min_o} !== exp_pk) begin
      failures++;
      $display("FAIL peak got=%h exp=%h",
        {peak_max_o, peak_min_o}, exp_pk);
    end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_burst();
    test_overflow();
    test_full_push_pop();
    test_abort();
    test_reset_mid_burst();
    test_peak();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_gen_driver.md
Name: wave_gen_driver

Overview:
- Host-side driver for the wave generator's control/sample interface: the opposite end of the enable/waveform/set-strobe/data-in and data-out/valid-strobe pins.
- Accepts one burst command per valid/ready handshake and programs amplitude, then phase, over the shared 8-bit data bus.
- Enables the generator for N valid samples and buffers the returned samples in a small FIFO with a valid/ready read port.
- Used in FPGA/test harnesses to drive the generator's pins and collect its output.

Parameters:
FIFO_DEPTH, 8, sample FIFO entries; power of two, >= 2
CNT_W, 16, width of sample-count field and counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  burst command valid
cmd_ready_o  out  1  high only in IDLE
cmd_amplitude_i  in  8  amplitude value
cmd_phase_i  in  8  phase value
cmd_waveform_i  in  2  waveform select, passed through unchanged
cmd_num_samples_i  in  CNT_W  samples to collect; 0 = continuous until abort
abort_i  in  1  level; ends burst
gen_enable_o  out  1  generator enable
gen_waveform_o  out  2  generator waveform select
gen_set_amplitude_strobe_o  out  1  one-cycle amplitude load strobe
gen_set_phase_strobe_o  out  1  one-cycle phase load strobe
gen_data_o  out  8  generator data bus
gen_data_i  in  8  generator sample
gen_data_valid_strobe_i  in  1  generator sample strobe
smp_valid_o  out  1  FIFO head valid
smp_data_o  out  8  FIFO head data
smp_ready_i  in  1  consumer pop
busy_o  out  1  state != IDLE
overflow_o  out  1  sticky: sample dropped because FIFO was full
done_strobe_o  out  1  one-cycle pulse at burst end
peak_max_o  out  8  see Optional Feature
peak_min_o  out  8  see Optional Feature

Behaviour:
- Reset values: every output is 0; state IDLE; FIFO empty; counter 0.
- FSM states: IDLE, SET_AMP, SET_PHASE, RUN, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - When cmd_valid_i is high, latch all cmd_* fields, clear overflow_o, and go to SET_AMP.
- SET_AMP (exactly 1 cycle): gen_data_o = amplitude; gen_set_amplitude_strobe_o = 1; next state SET_PHASE.
- SET_PHASE (exactly 1 cycle): gen_data_o = phase; gen_set_phase_strobe_o = 1; next state RUN.
- Strobes are registered outputs, so each pulse appears on the pins in the cycle after the state is entered.
- gen_waveform_o holds the latched waveform from command acceptance until the next command. gen_data_o holds its last value outside the set states.
- RUN:
  - gen_enable_o = 1.
  - Each gen_data_valid_strobe_i increments the counter. The sample is pushed to the FIFO, or dropped with overflow_o set if the FIFO is full.
  - Leave to DONE in the cycle the counter reaches num_samples (num_samples != 0), or when abort_i is high.
  - A strobe and abort in the same cycle: the sample is still captured.
- DONE (1 cycle): gen_enable_o = 0; done_strobe_o = 1; next state IDLE.
- abort_i in SET_AMP or SET_PHASE goes to DONE; strobes not yet issued are suppressed.
- Valid strobes are ignored outside RUN.
- FIFO:
  - First-word fall-through; smp_valid_o = not empty.
  - A push into an empty FIFO is visible on smp_valid_o the next cycle.
  - Pop happens when smp_valid_o && smp_ready_i.
  - Push and pop together when full: both happen, no overflow.
  - Push and pop together when empty: push only.
  - FIFO contents persist across commands and are not flushed by abort.
- Counter width is CNT_W. In continuous mode it wraps silently.
- Reset mid-burst: immediate return to IDLE; gen_enable_o and both strobes drop asynchronously; FIFO is emptied.

Optional Feature:
- Macro: WAVE_GEN_DRIVER_PEAK_DETECT_EN.
- Defined:
  - peak_max_o and peak_min_o track the signed (two's complement) maximum and minimum of samples captured in the current burst.
  - On command accept, initialize to max = 8'h80 and min = 8'h7F.
  - Dropped samples also update the peaks.
- Undefined: both ports tied to 0 and no peak logic is generated.

Decomposition:
- Package wave_gen_driver_pkg: state enum (IDLE, SET_AMP, SET_PHASE, RUN, DONE), 2-bit waveform type, PEAK_INIT_MAX = 8'h80, PEAK_INIT_MIN = 8'h7F.
- Sub-module wave_sample_fifo: parameterized sync FIFO with show-ahead head and count-based full/empty.

Test Plan:
- Cmd amp=8'h40, phase=8'h10, wf=2'b01, n=4, valid strobes every 3rd cycle -> amplitude strobe with gen_data_o=40, next cycle phase strobe with gen_data_o=10; enable high for exactly 4 strobes; done_strobe_o 1 cycle; FIFO holds 4 samples in order.
- n=12, FIFO_DEPTH=8, smp_ready_i=0 -> 8 samples stored; overflow_o=1 after the 9th strobe; done after the 12th.
- n=0, strobes every cycle, abort_i at cycle 20 -> enable drops in the DONE cycle; the sample coincident with abort is stored.
- Full FIFO, smp_ready_i=1 plus strobe in the same cycle -> count stays 8; no overflow; head advances.
- rst_i low during RUN -> enable and strobes 0 at once; smp_valid_o=0; cmd_ready_o=1 after release.
- With WAVE_GEN_DRIVER_PEAK_DETECT_EN, samples 8'h05, 8'hF0, 8'h7F -> peak_max_o = 8'h7F, peak_min_o = 8'hF0.
